// File: rtl/mr_issue_ctl.sv
// mr_issue_ctl: decode-to-ALU issue control with a register scoreboard, branch serialisation and taken-branch flush.
// Optional MR_ISSUE_STATS_EN enables the issue/stall statistics counters; otherwise they read as constant 0.
module mr_issue_ctl #(
  parameter int REGSEL_BITS  = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_BITS     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [REGSEL_BITS-1:0] id_rs1,
  input  logic                   id_rs1_used,
  input  logic [REGSEL_BITS-1:0] id_rs2,
  input  logic                   id_rs2_used,
  input  logic [REGSEL_BITS-1:0] id_dest_reg,
  input  logic                   id_is_branch,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  input  logic                   alu_jmp_done,
  input  logic                   alu_pc_valid,
  input  logic                   wb_valid,
  input  logic [REGSEL_BITS-1:0] wb_dest_reg,
  output logic                   flush,
  output logic [CNT_BITS-1:0]    inflight,
  output logic                   err,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_stalls
);
  localparam int NREG = 2 ** REGSEL_BITS;
  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_e;
  state_e                state_q;
  logic [NREG-1:0]       pend_q, pend_d;
  logic [CNT_BITS-1:0]   inflight_q, inflight_d;
  logic                  flush_q, err_q, hazard, issue, underflow;
  assign hazard = (id_rs1_used && id_rs1 != '0 && pend_q[id_rs1]) ||
                  (id_rs2_used && id_rs2 != '0 && pend_q[id_rs2]) ||
                  (id_dest_reg != '0 && pend_q[id_dest_reg]);
  assign issue = id_valid && alu_ready && state_q == RUN && !hazard &&
                 inflight_q < CNT_BITS'(MAX_INFLIGHT);
  assign id_ready  = issue;
  assign alu_valid = issue;
  assign flush     = flush_q;
  assign inflight  = inflight_q;
  assign err       = err_q;
  assign underflow = wb_valid && !issue && inflight_q == '0;
  assign inflight_d = (issue && !wb_valid) ? inflight_q + CNT_BITS'(1) :
                      (wb_valid && !issue && !underflow) ? inflight_q - CNT_BITS'(1) : inflight_q;
  // Scoreboard next state: retire clears first so a same-cycle issue to the same reg wins; x0 never pends.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid && wb_dest_reg != '0) pend_d[wb_dest_reg] = 1'b0;
    if (issue && id_dest_reg != '0) pend_d[id_dest_reg] = 1'b1;
    pend_d[0] = 1'b0;
  end
  // Branch FSM plus registered scoreboard, in-flight count, flush pulse and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pend_q     <= '0;
      inflight_q <= '0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      flush_q    <= 1'b0;
      err_q      <= err_q || underflow || (alu_jmp_done && state_q != BR_WAIT);
      case (state_q)
        RUN:     if (issue && id_is_branch) state_q <= BR_WAIT;
        BR_WAIT: if (alu_jmp_done) begin
          state_q <= alu_pc_valid ? FLUSH : RUN;
          flush_q <= alu_pc_valid;
        end
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end
`ifdef MR_ISSUE_STATS_EN
  logic [31:0] issued_q, stalls_q;
  assign stat_issued = issued_q;
  assign stat_stalls = stalls_q;
  // Free-running statistics, wrapping modulo 2**32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_q <= '0;
      stalls_q <= '0;
    end else begin
      issued_q <= issued_q + (issue ? 32'd1 : 32'd0);
      stalls_q <= stalls_q + ((id_valid && !issue) ? 32'd1 : 32'd0);
    end
  end
`else
  assign stat_issued = '0;
  assign stat_stalls = '0;
`endif
endmodule

// File: doc/mr_issue_ctl.md
Name: mr_issue_ctl

Overview:
- Issue controller between the decode stage and the ALU stage.
- Decides each cycle whether the decoded instruction may enter the ALU.
- Tracks in-flight destination registers in a scoreboard: stalls on RAW/WAW hazards (no bypass), serialises branches until the ALU resolves them, and pulses a front-end flush on taken branches.

Parameters:
- REGSEL_BITS, 5, register-select width; scoreboard has 2**REGSEL_BITS entries.
- MAX_INFLIGHT, 4, max issued-but-not-retired instructions (>=1).
- CNT_BITS, 3, width of in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decoded instruction present
- id_ready  out  1  combinational; instruction accepted this cycle (issue strobe)
- id_rs1  in  REGSEL_BITS  source reg 1
- id_rs1_used  in  1  rs1 is read
- id_rs2  in  REGSEL_BITS  source reg 2
- id_rs2_used  in  1  rs2 is read
- id_dest_reg  in  REGSEL_BITS  dest reg (0 = none)
- id_is_branch  in  1  branch op is not BROP_NEVER
- alu_valid  out  1  combinational; equals id_ready
- alu_ready  in  1  ALU can accept
- alu_jmp_done  in  1  ALU resolved a branch this cycle
- alu_pc_valid  in  1  resolved branch taken
- wb_valid  in  1  one pulse per retiring instruction
- wb_dest_reg  in  REGSEL_BITS  retiring dest (0 = none)
- flush  out  1  registered; one-cycle front-end kill
- inflight  out  CNT_BITS  registered in-flight count
- err  out  1  registered sticky protocol error
- stat_issued  out  32  issue count
- stat_stalls  out  32  stall-cycle count

Behaviour:
- Reset (rst_n=0 at posedge):
  - Clear all scoreboard bits; inflight=0; state=RUN.
  - flush=0, err=0, stat_issued=0, stat_stalls=0.
  - Aborts any branch wait or flush in progress; later alu_jmp_done/wb_valid pulses are handled normally.
- hazard, from registered scoreboard only (no same-cycle retire bypass) = any of:
  - id_rs1_used & rs1!=0 & pend[rs1]
  - id_rs2_used & rs2!=0 & pend[rs2]
  - id_dest_reg!=0 & pend[dest]
- issue = id_valid & alu_ready & state==RUN & !hazard & inflight<MAX_INFLIGHT.
  - id_ready = alu_valid = issue. Zero-latency decision; ALU captures on the same edge.
- Scoreboard update:
  - issue with dest!=0 sets pend[dest].
  - wb_valid with dest!=0 clears pend[wb_dest_reg].
  - Same reg set and cleared in one cycle: set wins.
  - pend[0] is always 0.
- inflight: +1 on issue, -1 on wb_valid; both together leaves it unchanged.
  - wb_valid with inflight==0 (and no issue): count holds, err<=1.
- States:
  - RUN: on issue with id_is_branch -> BR_WAIT.
  - BR_WAIT: id_ready=0.
    - alu_jmp_done & alu_pc_valid -> FLUSH.
    - alu_jmp_done & !alu_pc_valid -> RUN.
  - FLUSH: flush=1 for exactly this cycle, id_ready=0 -> RUN.
  - alu_jmp_done while in RUN or FLUSH: err<=1, no state change.
- Branch issue latency: earliest next issue is 2 cycles after branch issue (not-taken resolving the cycle after issue); 3 cycles if taken (extra FLUSH cycle).
- Retire and resolve may coincide with any state; scoreboard and counter update independent of state.
- err clears only on reset.

Optional Feature:
- MR_ISSUE_STATS_EN defined:
  - stat_issued += 1 on each issue.
  - stat_stalls += 1 each cycle id_valid & !issue.
  - Both wrap modulo 2**32 and reset to 0.
- Undefined: stat_issued and stat_stalls are constant 0, no counter logic; all other behaviour identical.

Test Plan:
- Issue x5=... then immediate reader of x5 (id_rs1=5, used) -> id_ready=0 until the cycle after wb_valid dest=5; then issues. stat_stalls counts the stall cycles.
- Reader of x0 (rs1=0) after writer of x0 -> no stall; pend[0] never set.
- 5 independent issues with no wb_valid, MAX_INFLIGHT=4 -> 4 issue, 5th stalls with inflight=4; one wb_valid -> 5th issues next cycle, inflight stays 4.
- Branch issue, alu_jmp_done=1 & alu_pc_valid=1 one cycle later -> flush=1 for exactly one cycle, next id_ready possible 3 cycles after branch issue; not-taken -> flush stays 0, issue possible 2 cycles after.
- wb_valid with inflight=0 -> err=1, inflight stays 0; rst_n low mid-BR_WAIT -> state RUN, all pend clear, err=0, inflight=0.
- Writer of x7 issued while wb_valid clears x7 the same cycle -> pend[7]=1 afterwards.
